// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath: steps subBytes, shiftRows,
// mixColumns and addRoundKey in AES order, one handshake at a time, with a per-step timeout.
module aes_round_ctrl #(
  parameter int NR  = 10,
  parameter int TMO = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sb_done,
  input  logic       sr_done,
  input  logic       mc_done,
  input  logic       ark_done,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  output logic       ark_en,
  output logic [1:0] ark_src,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE,
    EN_SB,
    WAIT_SB,
    EN_SR,
    WAIT_SR,
    EN_MC,
    WAIT_MC,
    EN_ARK,
    WAIT_ARK,
    DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  localparam logic [1:0] SRC_PT   = 2'd0;
  localparam logic [1:0] SRC_MC   = 2'd1;
  localparam logic [1:0] SRC_SR   = 2'd2;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [3:0] round_q;
  logic [1:0] src_q;
  logic       err_q;

  logic       in_wait;
  logic       step_done;
  logic       tmo_hit;
  logic       accept;
  logic       round_inc;
  logic       src_load;
  logic [1:0] src_nxt;

  // Only the done of the block currently being waited on is looked at.
  always_comb begin
    in_wait   = 1'b0;
    step_done = 1'b0;
    unique case (state)
      WAIT_SB:  begin in_wait = 1'b1; step_done = sb_done;  end
      WAIT_SR:  begin in_wait = 1'b1; step_done = sr_done;  end
      WAIT_MC:  begin in_wait = 1'b1; step_done = mc_done;  end
      WAIT_ARK: begin in_wait = 1'b1; step_done = ark_done; end
      default:  begin in_wait = 1'b0; step_done = 1'b0;     end
    endcase
  end

  // A done in the same cycle as the last allowed wait cycle still wins.
  assign tmo_hit = in_wait && !step_done && (wait_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    round_inc = 1'b0;
    src_load  = 1'b0;
    src_nxt   = src_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = EN_ARK;
          accept    = 1'b1;
          src_load  = 1'b1;
          src_nxt   = SRC_PT;
        end
      end
      EN_SB:   state_nxt = WAIT_SB;
      WAIT_SB: if (step_done) state_nxt = EN_SR;
      EN_SR:   state_nxt = WAIT_SR;
      WAIT_SR: begin
        if (step_done) begin
          if (round_q == LAST_RND) begin
            state_nxt = EN_ARK;
            src_load  = 1'b1;
            src_nxt   = SRC_SR;
          end else begin
            state_nxt = EN_MC;
          end
        end
      end
      EN_MC: state_nxt = WAIT_MC;
      WAIT_MC: begin
        if (step_done) begin
          state_nxt = EN_ARK;
          src_load  = 1'b1;
          src_nxt   = SRC_MC;
        end
      end
      EN_ARK: state_nxt = WAIT_ARK;
      WAIT_ARK: begin
        if (step_done) begin
          if (round_q == LAST_RND) begin
            state_nxt = DONE;
          end else begin
            state_nxt = EN_SB;
            round_inc = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter sits at zero outside WAIT states, so every WAIT starts from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (!in_wait) begin
      wait_cnt <= 8'd0;
    end else if (!step_done) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      round_q <= 4'd0;
      src_q   <= SRC_PT;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        round_q <= 4'd0;
      end else if (round_inc) begin
        round_q <= round_q + 4'd1;
      end
      if (src_load) begin
        src_q <= src_nxt;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sb_en     = (state == EN_SB);
  assign sr_en     = (state == EN_SR);
  assign mc_en     = (state == EN_MC);
  assign ark_en    = (state == EN_ARK);
  assign ark_src   = src_q;
  assign round_idx = round_q;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: step-order table plus stall, timeout, reset,
// back-to-back and spurious-input sequences.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  localparam int NR  = 10;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sb_done = 1'b0;
  logic       sr_done = 1'b0;
  logic       mc_done = 1'b0;
  logic       ark_done = 1'b0;
  logic       sb_en, sr_en, mc_en, ark_en;
  logic [1:0] ark_src;
  logic [3:0] round_idx;
  logic       busy, done, err;

  aes_round_ctrl #(.NR(NR), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done), .ark_done(ark_done),
    .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en), .ark_en(ark_en),
    .ark_src(ark_src), .round_idx(round_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // code: 0 SB, 1 SR, 2 MC, 3 ARK
  typedef struct {
    int code;
    int rnd;
    int src;
    int cyc;
  } step_t;

  step_t       exp_tab[40];
  step_t       evq[$];
  int          done_q[$];
  logic [12:0] outs_at[0:255];
  int          busy_cnt, multi_cnt;
  int          checks = 0;
  int          errors = 0;

  bit kill_mc = 0, stall_ark = 0, spur_sb = 0;
  int reset_at = -1;
  int start_mode = 0;
  int sb_c = 0, sr_c = 0, mc_c = 0, ark_c = 0;

  // Step-block responders: done one cycle after enable, with optional stall / drop / spurious.
  always @(posedge clk) begin
    #1;
    sb_done = 1'b0; sr_done = 1'b0; mc_done = 1'b0; ark_done = 1'b0;
    if (!reset) begin
      sb_c = 0; sr_c = 0; mc_c = 0; ark_c = 0;
    end else begin
      if (sb_c > 0)  begin sb_c--;  if (sb_c == 0)  sb_done = 1'b1;  end
      if (sr_c > 0)  begin sr_c--;  if (sr_c == 0)  sr_done = 1'b1;  end
      if (mc_c > 0)  begin mc_c--;  if (mc_c == 0)  mc_done = 1'b1;  end
      if (ark_c > 0) begin ark_c--; if (ark_c == 0) ark_done = 1'b1; end
      if (sb_en) sb_c = 1;
      if (sr_en) sr_c = 1;
      if (mc_en && !(kill_mc && round_idx == 4'd2)) mc_c = 1;
      if (ark_en) begin
        ark_c = (stall_ark && round_idx == 4'd5) ? 4 : 1;
        if (spur_sb) sb_c = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic bit start_at(input int mode, input int rel);
    case (mode)
      1:       return rel <= 90;
      2:       return rel == 0 || rel == 10 || rel == 41 || rel == 60 || rel == 81;
      default: return rel == 0;
    endcase
  endfunction

  // Cycle 0 is the cycle in which start is first sampled.
  task automatic run_test(input int ncyc);
    int n;
    evq.delete();
    done_q.delete();
    busy_cnt  = 0;
    multi_cnt = 0;
    for (int i = 0; i < 256; i++) outs_at[i] = '0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int rel = 0; rel < ncyc; rel++) begin
      @(negedge clk);
      outs_at[rel] = {sb_en, sr_en, mc_en, ark_en, ark_src, round_idx, busy, done, err};
      n = int'(sb_en) + int'(sr_en) + int'(mc_en) + int'(ark_en);
      if (n > 1) multi_cnt++;
      if (n > 0)
        evq.push_back('{code: (ark_en ? 3 : mc_en ? 2 : sr_en ? 1 : 0),
                        rnd: int'(round_idx), src: int'(ark_src), cyc: rel});
      if (busy) busy_cnt++;
      if (done) done_q.push_back(rel);
      start = start_at(start_mode, rel);
      reset = (rel == reset_at) ? 1'b0 : 1'b1;
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  function automatic int sig(input step_t s, input int cyc);
    return s.code * 1000000 + s.rnd * 10000 + ((s.code == 3) ? s.src : 0) * 1000 + cyc;
  endfunction

  task automatic check_steps(input string tag, input int stall_after, input int stall);
    int act;
    for (int k = 0; k < 40; k++) begin
      act = (evq.size() > k) ? sig(evq[k], evq[k].cyc) : -1;
      chk($sformatf("%s_step%0d", tag, k), act,
          sig(exp_tab[k], exp_tab[k].cyc + ((k > stall_after) ? stall : 0)));
    end
    chk({tag, "_onehot"}, multi_cnt, 0);
  endtask

  initial begin
    int k;
    exp_tab[0] = '{3, 0, 0, 1};
    k = 1;
    for (int r = 1; r <= NR; r++) begin
      exp_tab[k] = '{0, r, 0, 2 * k + 1}; k++;
      exp_tab[k] = '{1, r, 0, 2 * k + 1}; k++;
      if (r < NR) begin
        exp_tab[k] = '{2, r, 0, 2 * k + 1}; k++;
        exp_tab[k] = '{3, r, 1, 2 * k + 1}; k++;
      end else begin
        exp_tab[k] = '{3, r, 2, 2 * k + 1}; k++;
      end
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enables", int'({sb_en, sr_en, mc_en, ark_en}), 0);
    chk("rst_ark_src", int'(ark_src), 0);
    chk("rst_round", int'(round_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // nominal run
    start_mode = 0;
    run_test(90);
    check_steps("t1", 99, 0);
    chk("t1_nsteps", evq.size(), 40);
    chk("t1_done_cnt", done_q.size(), 1);
    chk("t1_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 81);
    chk("t1_busy_cnt", busy_cnt, 80);
    chk("t1_busy_c1", int'(outs_at[1][2]), 1);
    chk("t1_busy_c80", int'(outs_at[80][2]), 1);
    chk("t1_busy_c81", int'(outs_at[81][2]), 0);
    chk("t1_round_done", int'(outs_at[81][6:3]), 10);
    chk("t1_round_idle", int'(outs_at[85][6:3]), 10);
    chk("t1_err", int'(outs_at[85][0]), 0);

    // ark_done late by 3 cycles in round 5
    stall_ark = 1;
    run_test(90);
    stall_ark = 0;
    check_steps("t2", 20, 3);
    chk("t2_done_cnt", done_q.size(), 1);
    chk("t2_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 84);
    chk("t2_err", int'(outs_at[84][0]), 0);
    chk("t2_busy_cnt", busy_cnt, 83);

    // mc_done never arrives in round 2
    kill_mc = 1;
    run_test(40);
    kill_mc = 0;
    chk("t3_nsteps", evq.size(), 8);
    chk("t3_mc_en_c15", int'(outs_at[15][10]), 1);
    chk("t3_err_c30", int'(outs_at[30][0]), 0);
    chk("t3_err_c31", int'(outs_at[31][0]), 1);
    chk("t3_busy_c30", int'(outs_at[30][2]), 1);
    chk("t3_busy_c31", int'(outs_at[31][2]), 0);
    chk("t3_done_cnt", done_q.size(), 0);
    run_test(90);
    chk("t3b_err_c0", int'(outs_at[0][0]), 1);
    chk("t3b_err_c1", int'(outs_at[1][0]), 0);
    chk("t3b_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 81);

    // reset pulse during round-4 shiftRows wait
    reset_at = 30;
    run_test(45);
    reset_at = -1;
    chk("t4_round_c30", int'(outs_at[30][6:3]), 4);
    chk("t4_src_c30", int'(outs_at[30][8:7]), 1);
    chk("t4_busy_c30", int'(outs_at[30][2]), 1);
    chk("t4_outs_c31", int'(outs_at[31]), 0);
    chk("t4_busy_cnt", busy_cnt, 30);
    chk("t4_nsteps", evq.size(), 15);
    chk("t4_done_cnt", done_q.size(), 0);

    // start held high: back-to-back runs
    start_mode = 1;
    run_test(175);
    start_mode = 0;
    chk("t5_done_cnt", done_q.size(), 2);
    chk("t5_done0", (done_q.size() > 0) ? done_q[0] : -1, 81);
    chk("t5_done1", (done_q.size() > 1) ? done_q[1] : -1, 163);
    chk("t5_nsteps", evq.size(), 80);
    chk("t5_idle_c82", int'({outs_at[82][12:9], outs_at[82][2]}), 0);
    chk("t5_restart", (evq.size() > 40) ? sig(evq[40], evq[40].cyc) : -1, sig(exp_tab[0], 83));

    // spurious sb_done in WAIT_ARK, start pulses while busy and in DONE
    start_mode = 2;
    spur_sb = 1;
    run_test(95);
    spur_sb = 0;
    start_mode = 0;
    check_steps("t6", 99, 0);
    chk("t6_nsteps", evq.size(), 40);
    chk("t6_done_cnt", done_q.size(), 1);
    chk("t6_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 81);
    chk("t6_busy_cnt", busy_cnt, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
